// File: rtl/cmp_bist_if.sv
// Comparator-side bus between the BIST controller (master) and the comparator under test (slave).
interface cmp_bist_if #(
  parameter int N = 4
);
  logic [N-1:0] a_out;
  logic [N-1:0] b_out;
  logic         eq_in;
  logic         lw_in;
  logic         gr_in;

  modport master (output a_out, b_out, input eq_in, lw_in, gr_in);
  modport slave  (input a_out, b_out, output eq_in, lw_in, gr_in);
endinterface

// File: rtl/cmp_bist_ctrl.sv
// Exhaustive-sweep BIST controller for an N-bit magnitude comparator.
// Optional macro CMP_BIST_STOP_ON_ERROR_EN: finish the sweep at the first failing pair.
module cmp_bist_ctrl #(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  cmp_bist_if.master    cmp,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [2*N:0]  err_count,
  output logic          fail_valid,
  output logic [N-1:0]  fail_a,
  output logic [N-1:0]  fail_b
);

`ifdef CMP_BIST_STOP_ON_ERROR_EN
  localparam bit STOP_ON_ERROR = 1'b1;
`else
  localparam bit STOP_ON_ERROR = 1'b0;
`endif

  localparam int EW = 2 * N + 1;
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    a_q, b_q;
  logic [SW-1:0]   settle_cnt;
  logic [2*N-1:0]  pair_inc;
  logic            mismatch;
  logic            last_pair;
  logic            finish;

  assign cmp.a_out = a_q;
  assign cmp.b_out = b_q;

  // Any flag disagreeing counts, so non-one-hot flag patterns are caught too.
  assign mismatch  = (cmp.eq_in != (a_q == b_q)) ||
                     (cmp.lw_in != (a_q <  b_q)) ||
                     (cmp.gr_in != (a_q >  b_q));
  assign last_pair = &{a_q, b_q};
  assign finish    = last_pair || (STOP_ON_ERROR && mismatch);
  assign pair_inc  = {a_q, b_q} + (2 * N)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (SETTLE > 0) ? WAIT : CHECK;
      WAIT:       if (settle_cnt == SETTLE_LAST) state_nxt = CHECK;
      CHECK: begin
        if (finish)           state_nxt = DONE;
        else if (SETTLE > 0)  state_nxt = WAIT;
        else                  state_nxt = CHECK;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == WAIT) || (state == CHECK);
    done = (state == DONE);
    pass = (state == DONE) && (err_count == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q        <= '0;
            b_q        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
          end
        end
        WAIT: settle_cnt <= settle_cnt + SW'(1);
        CHECK: begin
          settle_cnt <= '0;
          if (mismatch) begin
            // At most 2^(2N) failures, which EW bits always hold.
            err_count <= err_count + EW'(1);
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_a     <= a_q;
              fail_b     <= b_q;
            end
          end
          // b carries into a through the concatenated increment.
          if (!finish) {a_q, b_q} <= pair_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cmp_bist_ctrl.md
# cmp_bist_ctrl

- Built-in self-test controller for the N-bit magnitude comparator. It sits on the comparator's input side and drives operand pairs `a`/`b` into the comparator.
- It samples the comparator's `equal`/`lower`/`greater` flags and checks them against internally computed expected values.
- The sweep covers every operand pair: `a` is the outer loop, `b` the inner loop, both from 0 to 2^N−1.
- Reports pass/fail, an error count and the first failing pair. Used for power-on self-test and bring-up of comparator instances.

## Interface
Parameters:
- `N`, 4, operand width in bits (≥1).
- `SETTLE`, 1, idle cycles between an operand update and flag sampling (≥0).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a sweep when in IDLE or DONE.
- `a_out`  out  N  operand A to comparator (registered).
- `b_out`  out  N  operand B to comparator (registered).
- `eq_in`  in  1  comparator `equal` flag.
- `lw_in`  in  1  comparator `lower` flag (a<b).
- `gr_in`  in  1  comparator `greater` flag (a>b).
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep finished; held until next `start`.
- `pass`  out  1  valid when `done`=1; 1 iff `err_count`==0.
- `err_count`  out  2N+1  number of failing pairs.
- `fail_valid`  out  1  at least one failure captured.
- `fail_a`, `fail_b`  out  N each  operands of the first failing pair.

## Operation
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE/DONE + `start`=1:
  - `a_out`=`b_out`=0.
  - `err_count`, `fail_valid`, `fail_a`, `fail_b`, `pass` cleared.
  - `busy`=1, `done`=0.
  - Next state is WAIT if `SETTLE`>0, else CHECK.
- WAIT: counts `SETTLE` cycles, then goes to CHECK. Operands are held stable.
- CHECK: compares the flags to the expected values.
  - Expected values: eq=(a==b), lw=(a<b), gr=(a>b), unsigned.
  - A pair fails if any of the three flags differs from its expected value. This includes non-one-hot flag combinations.
  - On failure: `err_count`+1. If `fail_valid`=0, capture `fail_a`/`fail_b` and set `fail_valid`=1.
  - Advance: `b_out`+1. When `b_out` wraps from 2^N−1 to 0, `a_out`+1. Re-enter WAIT/CHECK.
  - After checking the last pair (a=b=2^N−1): go to DONE, `busy`=0, `done`=1, `pass`=(err_count==0 including this pair). Operands stay at 2^N−1.
- `err_count` width 2N+1 holds the maximum value 2^(2N); it never wraps.
- `start` while `busy`=1 is ignored.
- Reset asserted at any time (including mid-sweep): all state returns to reset values immediately, with no clock needed. FSM returns to IDLE.

## Timing
- Reset values: `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `fail_a`=0, `fail_b`=0.
- Cycles per pair: `SETTLE`+1.
- Flags are sampled at the rising edge that ends the CHECK cycle. The comparator therefore has `SETTLE`+1 full cycles of stable operands.
- `busy` is high for exactly 2^(2N)·(`SETTLE`+1) cycles. Example: N=4, `SETTLE`=1 gives 512 cycles.
- `done` rises on the same edge that `busy` falls.
- `start` to first operand: operands are 0 and `busy`=1 on the first edge after `start` is sampled.
- `err_count`, `fail_*` and `pass` update on the edge ending CHECK.

## Configuration
- Macro: `CMP_BIST_STOP_ON_ERROR_EN`.
- Defined: on the first failing pair, CHECK goes directly to DONE with `err_count`=1 and `pass`=0. `a_out`/`b_out` hold the failing pair.
- Undefined (default): the sweep always covers all 2^(2N) pairs and counts every failure.

## Test plan
- Correct comparator model, N=4, `SETTLE`=1, `start` pulse:
  - `busy` high 512 cycles, then `done`=1, `pass`=1, `err_count`=0, `fail_valid`=0.
- `eq_in` stuck at 0, macro undefined:
  - `done` after 512 cycles, `err_count`=16, `pass`=0, `fail_a`=0, `fail_b`=0.
- `lw_in`/`gr_in` swapped, macro undefined:
  - `err_count`=240, first failure `fail_a`=0, `fail_b`=1.
- Same swap, macro defined:
  - `done` after 4 cycles (pairs 0/0, 0/1), `err_count`=1, `a_out`=0, `b_out`=1, `pass`=0.
- Mid-sweep checks:
  - `start` pulse at cycle 100: ignored; total sweep still 512 cycles.
  - `rst_n` low at cycle 200: all outputs return to reset values immediately.
  - Fresh `start` after reset: completes with `pass`=1.
- From DONE with `err_count`=16, issue `start`:
  - Counters clear on the next edge; the second sweep with a correct model ends with `pass`=1.
